mdom_wvb_acq_ctrl: RTL
======================

# mdom_wvb_acq_ctrl

Acquisition sequencer for one mDOM waveform buffer (WVB) channel. It consumes the fields carried by the WVB configuration bundle (cnst_conf, test_conf, post_conf, pre_conf, arm, trig_mode, cnst_run) and drives the buffer's write enable, trigger marker and event-complete handshake. It owns the pre-trigger fill, trigger acceptance, post-trigger capture, and the constant-rate and test-pulse period timers. It sits between the register-file bundle fan-out and the WVB write port.

## Interface
Parameters:
- none; widths are fixed by the configuration bundle.

Ports:
- clk  in  1  system clock; sole clock domain
- rst_n  in  1  asynchronous, active-low reset
- cnst_conf  in  12  constant-trigger period in clocks; 0 disables the timer
- test_conf  in  12  test-pulse period in clocks; 0 disables the timer
- post_conf  in  8  samples captured after the trigger sample
- pre_conf  in  5  samples captured before the trigger sample
- arm  in  1  level; 1 runs the acquisition, 0 aborts and idles
- trig_mode  in  1  0 = discriminator trigger, 1 = test-pulse trigger
- cnst_run  in  1  enables constant-rate forced triggers, ORed with trig_mode source
- disc_trig  in  1  discriminator trigger, synchronous single-cycle pulse
- wvb_full  in  1  buffer cannot accept another event
- evt_ack  in  1  buffer readout has latched the event
- wr_en  out  1  write current ADC sample into WVB
- trig_out  out  1  one-cycle marker for the trigger sample
- trig_src  out  2  source of the last accepted trigger: 01 = disc, 10 = test, 11 = cnst; valid with evt_valid
- evt_valid  out  1  event complete; held until evt_ack
- test_pulse  out  1  one-cycle test-injection strobe
- drop  out  1  one-cycle pulse: trigger discarded because wvb_full
- armed  out  1  state == ARMED

## Operation
- States: IDLE, PRE_FILL, ARMED, POST, DONE.
- IDLE: if arm=1, go to PRE_FILL, or directly to ARMED when pre_conf=0.
- PRE_FILL: wr_en=1 for exactly pre_conf cycles, counted 0..pre_conf-1, then ARMED. No triggers are accepted.
- ARMED: wr_en=1 (circular pre-trigger).
  - Candidate trigger: (trig_mode ? test_fire : disc_trig) OR (cnst_run & cnst_fire).
  - Simultaneous candidates: the trig_mode source wins over cnst for trig_src.
  - Candidate with wvb_full=0: this cycle's sample is the trigger sample. Go to POST, or to DONE when post_conf=0.
  - Candidate with wvb_full=1: pulse drop and stay in ARMED.
- POST: wr_en=1 for exactly post_conf cycles, then DONE. Triggers are ignored and not counted as drops.
- DONE: wr_en=0 and evt_valid=1 until evt_ack is sampled high. Then go to PRE_FILL/ARMED if arm=1, else IDLE.
- Event length is pre_conf + 1 + post_conf samples.
- Timers run in every state while arm=1 and are cleared while arm=0.
  - Each timer counts 0..conf-1 and fires on conf-1, then wraps to 0.
  - conf=1 fires every cycle; conf=0 never fires.
  - test_pulse is the test timer's fire.
  - Configuration changes take effect at the next wrap.
- arm=0 in any state other than IDLE: go to IDLE next cycle, with no evt_valid and no trig_out. A DONE event already presented is withdrawn.
- pre_conf and post_conf are sampled at PRE_FILL entry and at the ARMED→POST transition respectively. Changes mid-event do not alter the current event.

## Timing
- Reset value of every output is 0: wr_en, trig_out, trig_src=00, evt_valid, test_pulse, drop, armed. State is IDLE, counters and timers are 0.
- All outputs are registered; there is no combinational input→output path.
- wr_en follows the state: it is high in the cycles after the clock edge that enters PRE_FILL, ARMED or POST.
- A trigger sampled at edge n:
  - state = POST from edge n+1;
  - trig_out high for the cycle after edge n+1;
  - the buffer tags the sample written in the cycle ending at edge n.
- evt_valid rises on the first cycle after the edge that enters DONE. evt_ack sampled high at edge m drops evt_valid at m+1. evt_ack is ignored outside DONE.
- drop and test_pulse are one cycle wide, registered one cycle after the fire/condition.

## Structure
- Shared package mdom_wvb_pkg:
  - state enum;
  - TRIG_SRC_{NONE,DISC,TEST,CNST} constants;
  - bundle field widths (12/12/8/5).
- Sub-module mdom_wvb_period_timer (12-bit period, en, fire) is instantiated twice: constant timer and test timer.
- FSM and counters are in the top module.

## Test plan
- pre_conf=4, post_conf=10, trig_mode=0, arm=1, disc_trig at cycle 20 → wr_en high for exactly 15 samples around the trigger; trig_out one cycle; trig_src=01; evt_valid held until evt_ack, then wr_en resumes.
- pre_conf=0, post_conf=0, cnst_run=1, cnst_conf=50 → event every 50 clocks as long as ack is immediate; trig_src=11; 1-sample events.
- trig_mode=1, test_conf=100, cnst_run=1, cnst_conf=100 with aligned fire → trig_src=10; test_pulse every 100 clocks.
- wvb_full=1 in ARMED with disc_trig ×3 → three drop pulses, no state change. Deassert wvb_full, trigger once → normal event.
- arm dropped mid-POST and mid-DONE → IDLE next cycle, wr_en=0, evt_valid=0, timers cleared. Asynchronous rst_n mid-POST → all outputs 0 immediately.
- disc_trig during PRE_FILL and POST → ignored, no drop.

Source files
------------

// File: rtl/mdom_wvb_pkg.sv
// rtl/mdom_wvb_pkg.sv - shared types and constants for the mDOM WVB acquisition sequencer
package mdom_wvb_pkg;

  localparam int CNST_W  = 12;
  localparam int TEST_W  = 12;
  localparam int POST_W  = 8;
  localparam int PRE_W   = 5;
  localparam int TIMER_W = 12;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_PRE_FILL = 3'd1,
    ST_ARMED    = 3'd2,
    ST_POST     = 3'd3,
    ST_DONE     = 3'd4
  } state_e;

  localparam logic [1:0] TRIG_SRC_NONE = 2'b00;
  localparam logic [1:0] TRIG_SRC_DISC = 2'b01;
  localparam logic [1:0] TRIG_SRC_TEST = 2'b10;
  localparam logic [1:0] TRIG_SRC_CNST = 2'b11;

  // States in which the current ADC sample is written into the buffer
  function automatic logic writes_sample(input state_e s);
    return (s == ST_PRE_FILL) || (s == ST_ARMED) || (s == ST_POST);
  endfunction

endpackage

// File: rtl/mdom_wvb_period_timer.sv
// rtl/mdom_wvb_period_timer.sv - free-running period timer, fires on count period-1
module mdom_wvb_period_timer
  import mdom_wvb_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en_i,
  input  logic [TIMER_W-1:0] period_i,
  output logic               fire_o
);

  logic [TIMER_W-1:0] cnt_q, cnt_d;
  logic [TIMER_W-1:0] per_q, per_eff;

  // The period is picked up only at count 0, so a new value lands on the next wrap
  always_comb begin
    per_eff = (cnt_q == '0) ? period_i : per_q;
    fire_o  = en_i && (per_eff != '0) && (cnt_q == per_eff - TIMER_W'(1));
    if (!en_i || fire_o || (per_eff == '0)) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + TIMER_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      per_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      per_q <= en_i ? per_eff : '0;
    end
  end

endmodule

// File: rtl/mdom_wvb_acq_ctrl.sv
// rtl/mdom_wvb_acq_ctrl.sv - WVB acquisition sequencer: pre-fill, trigger, post capture, event handshake
module mdom_wvb_acq_ctrl
  import mdom_wvb_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic [CNST_W-1:0] cnst_conf,
  input  logic [TEST_W-1:0] test_conf,
  input  logic [POST_W-1:0] post_conf,
  input  logic [PRE_W-1:0]  pre_conf,
  input  logic              arm,
  input  logic              trig_mode,
  input  logic              cnst_run,
  input  logic              disc_trig,
  input  logic              wvb_full,
  input  logic              evt_ack,
  output logic              wr_en,
  output logic              trig_out,
  output logic [1:0]        trig_src,
  output logic              evt_valid,
  output logic              test_pulse,
  output logic              drop,
  output logic              armed
);

  logic cnst_fire, test_fire;

  mdom_wvb_period_timer u_cnst_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .en_i     (arm),
    .period_i (cnst_conf),
    .fire_o   (cnst_fire)
  );

  mdom_wvb_period_timer u_test_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .en_i     (arm),
    .period_i (test_conf),
    .fire_o   (test_fire)
  );

  state_e            state_q, state_d;
  logic [POST_W-1:0] cnt_q, cnt_d;
  logic [POST_W-1:0] len_q, len_d;
  logic [1:0]        trig_src_q, trig_src_d;
  logic              wr_en_q, trig_out_q, evt_valid_q, test_pulse_q, drop_q, armed_q;
  logic              primary, cand, accept, drop_d;
  logic [1:0]        cand_src;

  always_comb begin
    primary  = trig_mode ? test_fire : disc_trig;
    cand     = primary | (cnst_run & cnst_fire);
    cand_src = primary ? (trig_mode ? TRIG_SRC_TEST : TRIG_SRC_DISC) : TRIG_SRC_CNST;

    state_d    = state_q;
    cnt_d      = cnt_q;
    len_d      = len_q;
    trig_src_d = trig_src_q;
    accept     = 1'b0;
    drop_d     = 1'b0;

    if (!arm) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          cnt_d   = '0;
          len_d   = POST_W'(pre_conf);
          state_d = (pre_conf == '0) ? ST_ARMED : ST_PRE_FILL;
        end
        ST_PRE_FILL: begin
          if (cnt_q == len_q - POST_W'(1)) begin
            cnt_d   = '0;
            state_d = ST_ARMED;
          end else begin
            cnt_d = cnt_q + POST_W'(1);
          end
        end
        ST_ARMED: begin
          if (cand && wvb_full) begin
            drop_d = 1'b1;
          end else if (cand) begin
            accept     = 1'b1;
            trig_src_d = cand_src;
            cnt_d      = '0;
            len_d      = post_conf;
            state_d    = (post_conf == '0) ? ST_DONE : ST_POST;
          end
        end
        ST_POST: begin
          if (cnt_q == len_q - POST_W'(1)) begin
            cnt_d   = '0;
            state_d = ST_DONE;
          end else begin
            cnt_d = cnt_q + POST_W'(1);
          end
        end
        ST_DONE: begin
          if (evt_ack) begin
            cnt_d   = '0;
            len_d   = POST_W'(pre_conf);
            state_d = (pre_conf == '0) ? ST_ARMED : ST_PRE_FILL;
          end
        end
        default: begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // Outputs are decoded from the next state so they line up with the state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      len_q        <= '0;
      trig_src_q   <= TRIG_SRC_NONE;
      wr_en_q      <= 1'b0;
      trig_out_q   <= 1'b0;
      evt_valid_q  <= 1'b0;
      test_pulse_q <= 1'b0;
      drop_q       <= 1'b0;
      armed_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      len_q        <= len_d;
      trig_src_q   <= trig_src_d;
      wr_en_q      <= writes_sample(state_d);
      trig_out_q   <= accept;
      evt_valid_q  <= (state_d == ST_DONE);
      test_pulse_q <= test_fire;
      drop_q       <= drop_d;
      armed_q      <= (state_d == ST_ARMED);
    end
  end

  assign wr_en      = wr_en_q;
  assign trig_out   = trig_out_q;
  assign trig_src   = trig_src_q;
  assign evt_valid  = evt_valid_q;
  assign test_pulse = test_pulse_q;
  assign drop       = drop_q;
  assign armed      = armed_q;

endmodule
